// File: rtl/ntt_result_streamer.sv
// Drains the ntt_forward result RAM as a valid/ready stream once a transform completes.
// Optional macro BITREV_READ_EN: read addresses are bit-reversed so the output leaves in natural order.
module ntt_result_streamer #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ntt_done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [WIDTH-1:0]      read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  stream_done,
  output logic                  overrun
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_N    = (ADDR_WIDTH + 1)'(N);
  localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH + 1)'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_rd_cnt;
  logic [ADDR_WIDTH:0]   r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic                  r_dv;
  logic                  r_stream_done;
  logic                  r_overrun;
  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_pop;
  logic                  w_issue;
  logic                  w_final;
  logic [CW:0]           w_occ;
  logic [CW:0]           w_room;
  logic [ADDR_WIDTH:0]   w_rd_nxt;

  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef BITREV_READ_EN
    for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
      f_addr[i] = a[ADDR_WIDTH-1-i];
    end
`else
    f_addr = a;
`endif
  endfunction

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    f_ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid     = (r_count != '0);
  assign m_data      = r_mem[r_rd_ptr];
  assign m_last      = m_valid && (r_beat_cnt == LP_LAST);
  assign busy        = (r_state == S_STREAM);
  assign stream_done = r_stream_done;
  assign overrun     = r_overrun;
  assign read_addr   = r_read_addr;

  assign w_pop    = m_valid && m_ready;
  assign w_final  = w_pop && (r_beat_cnt == LP_LAST);
  assign w_rd_nxt = r_rd_cnt + 1'b1;
  // read_addr always presents rd_cnt; a read counts as issued in the cycle the
  // FIFO has room for its data, which lands one cycle later (r_dv).
  assign w_occ    = (CW + 1)'(r_count) + (CW + 1)'(r_dv);
  assign w_room   = (CW + 1)'(FIFO_DEPTH) + (CW + 1)'(w_pop);
  assign w_issue  = (r_state == S_STREAM) && (r_rd_cnt < LP_N) && (w_occ < w_room);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (ntt_done) w_state_nxt = S_STREAM;
      S_STREAM: if (w_final)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt      <= '0;
      r_beat_cnt    <= '0;
      r_read_addr   <= '0;
      r_dv          <= 1'b0;
      r_stream_done <= 1'b0;
      r_overrun     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_overrun     <= ntt_done && (r_state == S_STREAM);
      r_stream_done <= w_final;
      r_dv          <= w_issue;
      if (r_state == S_IDLE) begin
        r_rd_cnt    <= '0;
        r_beat_cnt  <= '0;
        r_read_addr <= '0;
      end else begin
        if (w_issue) begin
          r_rd_cnt <= w_rd_nxt;
          if (r_rd_cnt < LP_LAST) r_read_addr <= f_addr(w_rd_nxt[ADDR_WIDTH-1:0]);
        end
        if (w_pop) r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (r_dv) begin
        r_mem[r_wr_ptr] <= read_data;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(r_dv) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_ntt_result_streamer.sv
// Scoreboard bench for ntt_result_streamer: random RAM contents, random backpressure,
// overrun, mid-stream reset and prefetch stall; honours BITREV_READ_EN when defined.
module tb_ntt_result_streamer;

  localparam int N          = 256;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int FIFO_DEPTH = 2;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ntt_done = 1'b0;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [WIDTH-1:0]      read_data = '0;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic [WIDTH-1:0]      m_data;
  logic                  m_last;
  logic                  busy;
  logic                  stream_done;
  logic                  overrun;

  logic [WIDTH-1:0] mem [N];
  exp_t             exp_q [$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               start = 0;
  int               acc_total = 0;
  int               rdy_mode = 0;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  ntt_result_streamer #(
    .N(N), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ntt_done(ntt_done), .read_addr(read_addr),
    .read_data(read_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .stream_done(stream_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) read_data <= mem[read_addr];

  function automatic int brv(input int k);
    int r = 0;
    int x = k;
    for (int b = 0; b < ADDR_WIDTH; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int word_of_beat(input int k);
`ifdef BITREV_READ_EN
    return brv(k);
`else
    return k;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        2:       m_ready = ($urandom_range(99) < 30);
        default: m_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_last, m_data}, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.d);
          check("beat_last", m_last, e.l);
        end
        acc_total++;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic load_and_expect();
    for (int k = 0; k < N; k++) mem[k] = $urandom;
    for (int k = 0; k < N; k++) exp_q.push_back('{d: mem[word_of_beat(k)], l: (k == N - 1)});
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1 ntt_done = 1'b1;
    start = cyc;
    @(posedge clk);
    #1 ntt_done = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (stream_done) break;
      n++;
    end
    check({name, "_done_in_time"}, n < 3000, 1);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int base, input int cnt);
    int n = 0;
    while ((acc_total - base) < cnt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("beat_wait_in_time", n < 3000, 1);
  endtask

  task automatic run_timed();
    int first_v = -1;
    int last_rel = -1;
    int done_rel = -1;
    logic busy1 = 1'b0;
    logic busy_done = 1'b1;
    int rel;
    rdy_mode = 0;
    load_and_expect();
    pulse_done();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rel = cyc - start;
      if (rel == 1) busy1 = busy;
      if (m_valid && first_v < 0) first_v = rel;
      if (m_valid && m_last) last_rel = rel;
      if (stream_done) begin
        done_rel  = rel;
        busy_done = busy;
        break;
      end
    end
    check("busy_cycle1", busy1, 1);
    check("first_valid_cycle", first_v, 3);
    check("last_cycle", last_rel, N + 2);
    check("done_cycle", done_rel, N + 3);
    check("busy_after_done", busy_done, 0);
    check("timed_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    logic [ADDR_WIDTH-1:0] held;
    for (int k = 0; k < N; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {read_addr, m_valid, m_data, m_last, busy, stream_done, overrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // full-rate stream with exact latencies
    run_timed();

    // alternating and random backpressure
    rdy_mode = 1;
    load_and_expect();
    pulse_done();
    wait_done("toggle");
    rdy_mode = 2;
    load_and_expect();
    pulse_done();
    wait_done("random");

    // ntt_done while busy
    load_and_expect();
    base = acc_total;
    pulse_done();
    wait_beats(base, 100);
    @(posedge clk);
    #1 ntt_done = 1'b1;
    @(negedge clk);
    check("overrun_not_early", overrun, 0);
    @(posedge clk);
    #1 ntt_done = 1'b0;
    @(negedge clk);
    check("overrun_pulse", overrun, 1);
    check("busy_during_overrun", busy, 1);
    @(negedge clk);
    check("overrun_one_cycle", overrun, 0);
    wait_done("overrun");

    // reset mid-stream then restart
    load_and_expect();
    base = acc_total;
    pulse_done();
    wait_beats(base, 50);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {read_addr, m_valid, m_data, m_last, busy, stream_done, overrun}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_timed();

    // downstream stall: prefetch stops at FIFO_DEPTH words
    rdy_mode = 3;
    repeat (2) @(posedge clk);
    load_and_expect();
    pulse_done();
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_first_valid", m_valid, 1);
    held = read_addr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read_addr !== held) check("stall_addr_hold", read_addr, held);
    end
    check("stall_addr", read_addr, word_of_beat(FIFO_DEPTH));
    @(posedge clk);
    #1 rdy_mode = 0;
    start = cyc;
    n = 0;
    while (!stream_done && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("resume_full_rate", cyc - start, N);
    check("stall_queue_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
